seq_add_sub: RTL and testbench

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/addsub_pkg.sv | 15 +
 rtl/add_chunk.sv | 29 ++
 rtl/seq_add_sub.sv | 168 ++++++++++++++++
 tb/tb_seq_add_sub.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits added per cycle
//   state_t               : controller state encoding (IDLE, RUN, DONE)
package addsub_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : addsub_pkg

// File: rtl/add_chunk.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
// Ports:
//   A, B : addends
//   Ci   : carry-in to bit 0
//   S    : sum
//   Co   : carry-out of the top bit
module add_chunk #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  logic [WIDTH:0] c;

  assign c[0] = Ci;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Co = c[WIDTH];

endmodule : add_chunk

// File: rtl/seq_add_sub.sv
// Sequential add/subtract: processes one CHUNK-bit slice per clock, LSB
// slice first, then presents S/Co/V/Z with a one-cycle done pulse.
// Optional feature: define SEQ_ADD_SUB_SAT_EN to clamp S to the signed
// max/min on overflow (V still reports the overflow).
// Ports:
//   clk, reset      : clock (rising edge), async active-high reset
//   start, sub      : begin operation; 0 = add, 1 = subtract
//   A, B, Ci        : operands and add-mode carry-in
//   ready, done     : accepting start (IDLE only); result-valid pulse
//   S, Co, V, Z     : result, carry-out (1 = no borrow on subtract),
//                     signed overflow, result-is-zero
module seq_add_sub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // effective B (already inverted for subtract)
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               v_q, v_d;
  logic               z_q, z_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [IDX_W-1:0]   lo_c;
  logic [CHUNK-1:0]   slice_s_c;
  logic               slice_co_c;
  logic [WIDTH-1:0]   res_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   fin_c;
  logic               last_c;

  // Bit offset of the slice handled this cycle.
  assign lo_c   = IDX_W'(32'(cnt_q) * CHUNK);
  assign last_c = (cnt_q == CNT_W'(N - 1));

  add_chunk #(.WIDTH(CHUNK)) u_add_chunk (
    .A  (a_q[lo_c +: CHUNK]),
    .B  (b_q[lo_c +: CHUNK]),
    .Ci (carry_q),
    .S  (slice_s_c),
    .Co (slice_co_c)
  );

  // Accumulated result with the current slice merged in; overflow and
  // optional clamp are evaluated on it when the top slice completes.
  always_comb begin
    res_c               = sum_q;
    res_c[lo_c +: CHUNK] = slice_s_c;
    ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
    fin_c = res_c;
`ifdef SEQ_ADD_SUB_SAT_EN
    if (ovf_c) begin
      fin_c = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub | Ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = res_c;
        carry_d = slice_co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          cnt_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
          s_d     = fin_c;
          co_d    = slice_co_c;
          v_d     = ovf_c;
          z_d     = (fin_c == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Co    = co_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule : seq_add_sub

// File: tb/tb_seq_add_sub.sv
module tb_seq_add_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, sub, Ci;
  logic [15:0] A, B;
  logic        ready, done, Co, V, Z;
  logic [15:0] S;

  logic        start16, sub16, Ci16;
  logic [15:0] A16, B16;
  logic        ready16, done16, Co16, V16, Z16;
  logic [15:0] S16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .Ci(Ci),
    .ready(ready), .done(done), .S(S), .Co(Co), .V(V), .Z(Z)
  );

  seq_add_sub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16), .A(A16), .B(B16), .Ci(Ci16),
    .ready(ready16), .done(done16), .S(S16), .Co(Co16), .V(V16), .Z(Z16)
  );

  // Reference: signed/unsigned integer arithmetic. Returns {S, Co, V, Z}.
  function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
    int          sa, sv, r;
    logic [15:0] s;
    logic        co, v, z;
    sa = int'($signed(a));
    sv = int'($signed(b));
    if (sb) begin
      r  = sa - sv;
      co = (a >= b);
    end else begin
      r  = sa + sv + int'(ci);
      co = (32'(a) + 32'(b) + 32'(ci)) > 32'h0000_FFFF;
    end
    v = (r > 32767) || (r < -32768);
    s = r[15:0];
`ifdef SEQ_ADD_SUB_SAT_EN
    if (v) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    z = (s == 16'h0000);
    return {s, co, v, z};
  endfunction

  // Drive one operation on the CHUNK=4 instance; lat = edges after k until
  // done seen (-1 on timeout); rdy_bad set if ready was high before done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, output int lat, output logic rdy_bad);
    @(negedge clk);
    A = a; B = b; Ci = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    lat     = -1;
    rdy_bad = ready | done;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (ready) rdy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; sub = 1'b0; Ci = 1'b0; A = '0; B = '0;
    start16 = 1'b0; sub16 = 1'b0; Ci16 = 1'b0; A16 = '0; B16 = '0;
    #2;
    checks++;
    if ({ready, done, S, Co, V, Z} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b done=%b S=%h Co=%b V=%b Z=%b, want ready=1 done=0 S=0000 Co=0 V=0 Z=0",
               ready, done, S, Co, V, Z);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int          lat;
    logic        rb;
    logic [15:0] exp_s;
    // 0xFFFF + 1: wraps to zero with carry out, latency N = 4
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat !== 4 || rb !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap_timing: got latency=%0d ready_early=%b, want 4 and 0", lat, rb);
    end
    checks++;
    if ({S, Co, V, Z} !== {16'h0000, 3'b101}) begin
      errors++;
      $display("FAIL add_wrap_result: got S=%h Co=%b V=%b Z=%b, want S=0000 Co=1 V=0 Z=1", S, Co, V, Z);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b ready=%b one cycle later, want done=0 ready=1", done, ready);
    end
    // 0x7FFF + 1: signed overflow
`ifdef SEQ_ADD_SUB_SAT_EN
    exp_s = 16'h7FFF;
`else
    exp_s = 16'h8000;
`endif
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, rb);
    checks++;
    if (lat !== 4 || {S, Co, V, Z} !== {exp_s, 3'b010}) begin
      errors++;
      $display("FAIL add_overflow: got lat=%0d S=%h Co=%b V=%b Z=%b, want lat=4 S=%h Co=0 V=1 Z=0",
               lat, S, Co, V, Z, exp_s);
    end
    // 5 - 7 with Ci=1 (ignored in subtract)
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, rb);
    checks++;
    if (lat !== 4 || {S, Co, V, Z} !== {16'hFFFE, 3'b000}) begin
      errors++;
      $display("FAIL sub_borrow: got lat=%0d S=%h Co=%b V=%b Z=%b, want lat=4 S=fffe Co=0 V=0 Z=0",
               lat, S, Co, V, Z);
    end
    // Result holds through idle cycles
    repeat (5) @(negedge clk);
    checks++;
    if ({S, Co, V, Z, done} !== {16'hFFFE, 4'b0000}) begin
      errors++;
      $display("FAIL result_hold: got S=%h Co=%b V=%b Z=%b done=%b, want S=fffe Co=0 V=0 Z=0 done=0",
               S, Co, V, Z, done);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic        rb;
    logic [15:0] a, b;
    logic        ci, sb;
    logic [18:0] exp;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      if (i % 8 == 0) b = sb ? a : 16'(-int'(a));   // steer toward zero results
      exp = ref_model(a, b, ci, sb);
      run_op(a, b, ci, sb, lat, rb);
      checks++;
      if (lat !== 4 || rb !== 1'b0 || {S, Co, V, Z} !== exp) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h ci=%b sub=%b got lat=%0d rdy_early=%b {S,Co,V,Z}=%h, want lat=4 rdy_early=0 %h",
                 i, a, b, ci, sb, lat, rb, {S, Co, V, Z}, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    int   lat;
    logic rb;
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Different operands held on the inputs with start high during RUN
    A = 16'h7777; B = 16'h0F0F; sub = 1'b1; Ci = 1'b1;
    lat = -1;
    rb  = ready;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (ready) rb = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (lat !== 4 || rb !== 1'b0 || {S, Co, V, Z} !== {16'h3333, 3'b000}) begin
      errors++;
      $display("FAIL start_during_run: got lat=%0d rdy_early=%b S=%h Co=%b V=%b Z=%b, want lat=4 rdy_early=0 S=3333 Co=0 V=0 Z=0",
               lat, rb, S, Co, V, Z);
    end
    rb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || !ready) rb = 1'b1;
    end
    checks++;
    if (rb !== 1'b0 || S !== 16'h3333) begin
      errors++;
      $display("FAIL no_second_op: got spurious_activity=%b S=%h, want 0 and S=3333", rb, S);
    end
  endtask

  task automatic test_reset_midop();
    int   lat;
    logic rb;
    @(negedge clk);
    A = 16'h0101; B = 16'h0202; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);      // edge k+2
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, done, S, Co, V, Z} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_midop: got ready=%b done=%b S=%h Co=%b V=%b Z=%b, want ready=1 done=0 S=0000 Co=0 V=0 Z=0",
               ready, done, S, Co, V, Z);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || !ready) rb = 1'b1;
    end
    checks++;
    if (rb !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got activity after reset=%b, want 0", rb);
    end
    run_op(16'h4000, 16'h1234, 1'b1, 1'b0, lat, rb);
    checks++;
    if (lat !== 4 || {S, Co, V, Z} !== {16'h5235, 3'b000}) begin
      errors++;
      $display("FAIL post_reset_op: got lat=%0d S=%h Co=%b V=%b Z=%b, want lat=4 S=5235 Co=0 V=0 Z=0",
               lat, S, Co, V, Z);
    end
  endtask

  task automatic test_chunk16();
    int lat;
    @(negedge clk);
    A16 = 16'h1234; B16 = 16'h0001; Ci16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done16) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 1 || {S16, Co16, V16, Z16} !== {16'h1235, 3'b000}) begin
      errors++;
      $display("FAIL chunk16_add: got lat=%0d S=%h Co=%b V=%b Z=%b, want lat=1 S=1235 Co=0 V=0 Z=0",
               lat, S16, Co16, V16, Z16);
    end
    @(negedge clk);
    checks++;
    if (done16 !== 1'b0 || ready16 !== 1'b1) begin
      errors++;
      $display("FAIL chunk16_return: got done=%b ready=%b, want done=0 ready=1", done16, ready16);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midop();
    test_chunk16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_add_sub
